// File: rtl/sequence_generator.sv
// Serial pattern transmitter: latches a parallel pattern on a valid/ready command
// and shifts it out MSB-first on x, optionally repeated with an idle gap.
module sequence_generator #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4,
   parameter int GAP   = 1,
   localparam int LW   = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   // Command handshake: a command is taken on a rising edge where
   // start_valid && start_ready; start_ready is high exactly when idle.
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] pattern,
   input  logic [LW-1:0]    len,
   input  logic [CNT_W-1:0] reps,
   input  logic             abort,
   output logic             x,
   output logic             x_valid,
   output logic             busy,
   output logic             done,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   localparam int RW = CNT_W + 1;
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [GW-1:0] GAP_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pat_q, pat_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [LW-1:0]    len_q, len_d;
   logic [LW-1:0]    bit_q, bit_d;
   logic [RW-1:0]    rep_q, rep_d;
   logic [RW-1:0]    reps_q, reps_d;
   logic [GW-1:0]    gap_q, gap_d;
   logic             x_d, xv_d, busy_d, done_d;

   logic             accept, cancel, last_bit, last_rep, gap_end;
   logic [LW-1:0]    len_eff;
   logic [RW-1:0]    reps_eff;
   logic [WIDTH-1:0] aligned;

   assign start_ready = (state_q == S_IDLE);
   assign state_dbg   = state_q;
   assign accept      = start_valid && (state_q == S_IDLE);
   assign cancel      = abort && (state_q != S_IDLE);
   assign len_eff     = ((len == '0) || (len > LW'(WIDTH))) ? LW'(WIDTH) : len;
   assign reps_eff    = (reps == '0) ? RW'(1) : {1'b0, reps};
   // Left-align the pattern so the first bit to send always sits in the MSB.
   assign aligned     = pattern << (LW'(WIDTH) - len_eff);
   assign last_bit    = (bit_q == '0);
   assign last_rep    = (rep_q == reps_q);
   assign gap_end     = (gap_q == GAP_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_SHIFT;
         S_SHIFT: begin
            if (cancel)                    state_d = S_IDLE;
            else if (last_bit && last_rep) state_d = S_IDLE;
            else if (last_bit && GAP > 0)  state_d = S_GAP;
         end
         S_GAP: begin
            if (cancel)       state_d = S_IDLE;
            else if (gap_end) state_d = S_SHIFT;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Next values of the registered outputs and the datapath; an abort simply
   // leaves every output at its zero default.
   always_comb begin
      pat_d   = pat_q;
      shreg_d = shreg_q;
      len_d   = len_q;
      bit_d   = bit_q;
      rep_d   = rep_q;
      reps_d  = reps_q;
      gap_d   = gap_q;
      x_d     = 1'b0;
      xv_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               pat_d   = aligned;
               len_d   = len_eff;
               reps_d  = reps_eff;
               rep_d   = RW'(1);
               gap_d   = '0;
               bit_d   = len_eff - LW'(1);
               x_d     = aligned[WIDTH-1];
               shreg_d = aligned << 1;
               xv_d    = 1'b1;
               busy_d  = 1'b1;
            end
         end
         S_SHIFT: begin
            if (!cancel) begin
               if (!last_bit) begin
                  bit_d   = bit_q - LW'(1);
                  x_d     = shreg_q[WIDTH-1];
                  shreg_d = shreg_q << 1;
                  xv_d    = 1'b1;
                  busy_d  = 1'b1;
               end else if (last_rep) begin
                  done_d = 1'b1;
               end else begin
                  rep_d  = rep_q + RW'(1);
                  busy_d = 1'b1;
                  if (GAP > 0) begin
                     gap_d = '0;
                  end else begin
                     bit_d   = len_q - LW'(1);
                     x_d     = pat_q[WIDTH-1];
                     shreg_d = pat_q << 1;
                     xv_d    = 1'b1;
                  end
               end
            end
         end
         S_GAP: begin
            if (!cancel) begin
               busy_d = 1'b1;
               if (gap_end) begin
                  bit_d   = len_q - LW'(1);
                  x_d     = pat_q[WIDTH-1];
                  shreg_d = pat_q << 1;
                  xv_d    = 1'b1;
               end else begin
                  gap_d = gap_q + GW'(1);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pat_q   <= '0;
         shreg_q <= '0;
         len_q   <= '0;
         bit_q   <= '0;
         rep_q   <= '0;
         reps_q  <= '0;
         gap_q   <= '0;
         x       <= 1'b0;
         x_valid <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         pat_q   <= pat_d;
         shreg_q <= shreg_d;
         len_q   <= len_d;
         bit_q   <= bit_d;
         rep_q   <= rep_d;
         reps_q  <= reps_d;
         gap_q   <= gap_d;
         x       <= x_d;
         x_valid <= xv_d;
         busy    <= busy_d;
         done    <= done_d;
      end
   end

endmodule

// File: tb/tb_sequence_generator.sv
// Bench for sequence_generator: GAP=1 and GAP=0 instances share stimulus; a queue
// model of the expected output stream is checked every cycle, plus literal traces.
module tb_sequence_generator;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start_valid, abort;
   logic [7:0] pattern;
   logic [3:0] len;
   logic [3:0] reps;

   logic       rdy_g1, x_g1, xv_g1, busy_g1, done_g1;
   logic       rdy_g0, x_g0, xv_g0, busy_g0, done_g0;
   logic [1:0] st_g1, st_g0;

   int checks = 0;
   int failures = 0;

   // Expected per-cycle outputs, packed as {x, x_valid, busy, done}.
   logic [3:0] exp_q1[$];
   logic [3:0] exp_q0[$];
   logic [3:0] cur1 = 4'b0;
   logic [3:0] cur0 = 4'b0;

   logic [31:0] cx1, cv1, cb1, cd1, cx0, cv0, cb0, cd0;

   always #5 clk = ~clk;

   sequence_generator #(.WIDTH(8), .CNT_W(4), .GAP(1)) dut_g1 (
      .clk(clk), .reset_n(reset_n), .start_valid(start_valid), .start_ready(rdy_g1),
      .pattern(pattern), .len(len), .reps(reps), .abort(abort),
      .x(x_g1), .x_valid(xv_g1), .busy(busy_g1), .done(done_g1), .state_dbg(st_g1));

   sequence_generator #(.WIDTH(8), .CNT_W(4), .GAP(0)) dut_g0 (
      .clk(clk), .reset_n(reset_n), .start_valid(start_valid), .start_ready(rdy_g0),
      .pattern(pattern), .len(len), .reps(reps), .abort(abort),
      .x(x_g0), .x_valid(xv_g0), .busy(busy_g0), .done(done_g0), .state_dbg(st_g0));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Whole transmission as a list of cycles: bits, gap cycles, then the done cycle.
   task automatic gen(input bit which, input logic [7:0] p, input int l, input int r);
      int le, re, g;
      logic [3:0] v;
      le = (l == 0 || l > 8) ? 8 : l;
      re = (r == 0) ? 1 : r;
      g  = which ? 1 : 0;
      for (int rr = 0; rr < re; rr++) begin
         for (int i = le - 1; i >= 0; i--) begin
            v = {p[i], 3'b110};
            if (which) exp_q1.push_back(v); else exp_q0.push_back(v);
         end
         if (rr < re - 1)
            for (int k = 0; k < g; k++)
               if (which) exp_q1.push_back(4'b0010); else exp_q0.push_back(4'b0010);
      end
      if (which) exp_q1.push_back(4'b0001); else exp_q0.push_back(4'b0001);
   endtask

   always @(posedge clk) begin
      if (reset_n) begin
         if (!cur1[1] && start_valid) begin
            exp_q1.delete();
            gen(1'b1, pattern, int'(len), int'(reps));
         end else if (cur1[1] && abort) begin
            exp_q1.delete();
         end
         cur1 = (exp_q1.size() > 0) ? exp_q1.pop_front() : 4'b0;
         if (!cur0[1] && start_valid) begin
            exp_q0.delete();
            gen(1'b0, pattern, int'(len), int'(reps));
         end else if (cur0[1] && abort) begin
            exp_q0.delete();
         end
         cur0 = (exp_q0.size() > 0) ? exp_q0.pop_front() : 4'b0;
      end
   end

   always @(negedge reset_n) begin
      exp_q1.delete();
      exp_q0.delete();
      cur1 = 4'b0;
      cur0 = 4'b0;
   end

   always @(negedge clk) begin
      if (reset_n) begin
         chk("model_g1", {28'b0, x_g1, xv_g1, busy_g1, done_g1}, {28'b0, cur1});
         chk("ready_g1", {31'b0, rdy_g1}, {31'b0, ~cur1[1]});
         chk("state_g1", {31'b0, st_g1 != 2'd0}, {31'b0, cur1[1]});
         chk("model_g0", {28'b0, x_g0, xv_g0, busy_g0, done_g0}, {28'b0, cur0});
         chk("ready_g0", {31'b0, rdy_g0}, {31'b0, ~cur0[1]});
         chk("state_g0", {31'b0, st_g0 != 2'd0}, {31'b0, cur0[1]});
      end
   end

   task automatic issue(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
      @(posedge clk); #1;
      start_valid = 1'b1;
      pattern = p; len = l; reps = r;
      @(posedge clk); #1;
      start_valid = 1'b0;
      pattern = 8'($urandom); len = 4'($urandom); reps = 4'($urandom);
   endtask

   // Records outputs of cycles 1..n after the accept edge into bit c of each vector.
   task automatic capture(input int n, input int ac, input int sv_from, input int sv_to,
                          input logic [7:0] p2, input logic [3:0] l2, input logic [3:0] r2);
      cx1 = 0; cv1 = 0; cb1 = 0; cd1 = 0; cx0 = 0; cv0 = 0; cb0 = 0; cd0 = 0;
      for (int c = 1; c <= n; c++) begin
         abort = (c == ac);
         start_valid = (c >= sv_from && c <= sv_to);
         if (start_valid) begin pattern = p2; len = l2; reps = r2; end
         @(negedge clk);
         cx1[c] = x_g1; cv1[c] = xv_g1; cb1[c] = busy_g1; cd1[c] = done_g1;
         cx0[c] = x_g0; cv0[c] = xv_g0; cb0[c] = busy_g0; cd0[c] = done_g0;
         @(posedge clk); #1;
      end
      abort = 1'b0;
      start_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!busy_g1 && !busy_g0 && !done_g1 && !done_g0) begin ok = 1'b1; break; end
      end
      chk("idle_timeout", {31'b0, ok}, 32'd1);
   endtask

   function automatic logic [31:0] detect(input logic [31:0] xs, input logic [31:0] xv, input int n);
      logic [3:0]  hist;
      logic [31:0] det;
      hist = 4'b0;
      det  = 32'b0;
      for (int c = 1; c <= n; c++) begin
         hist   = {hist[2:0], xs[c] & xv[c]};
         det[c] = (hist == 4'b1101);
      end
      return det;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; start_valid = 1'b0; abort = 1'b0;
      pattern = 8'h00; len = 4'd0; reps = 4'd0;
      #12;
      chk("rst_outs_g1", {28'b0, x_g1, xv_g1, busy_g1, done_g1}, 32'h0);
      chk("rst_outs_g0", {28'b0, x_g0, xv_g0, busy_g0, done_g0}, 32'h0);
      #10 reset_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", {30'b0, rdy_g1, rdy_g0}, 32'h3);

      // Single 4-bit pattern
      issue(8'h0D, 4'd4, 4'd1);
      capture(6, 0, 0, -1, 8'h0, 4'd0, 4'd0);
      chk("s1_x", cx1, 32'h16);  chk("s1_xv", cv1, 32'h1E);
      chk("s1_busy", cb1, 32'h1E); chk("s1_done", cd1, 32'h20);
      chk("s1_x_g0", cx0, 32'h16); chk("s1_done_g0", cd0, 32'h20);
      wait_idle();

      // Three repetitions, with and without the gap
      issue(8'h0D, 4'd4, 4'd3);
      capture(16, 0, 0, -1, 8'h0, 4'd0, 4'd0);
      chk("s2_x_g1", cx1, 32'h5AD6); chk("s2_xv_g1", cv1, 32'h7BDE);
      chk("s2_busy_g1", cb1, 32'h7FFE); chk("s2_done_g1", cd1, 32'h8000);
      chk("s2_x_g0", cx0, 32'h1776); chk("s2_xv_g0", cv0, 32'h1FFE);
      chk("s2_done_g0", cd0, 32'h2000);
      wait_idle();

      // Length clamp: len=0, then len=WIDTH+3 with reps=0
      issue(8'hA5, 4'd0, 4'd1);
      capture(10, 0, 0, -1, 8'h0, 4'd0, 4'd0);
      chk("s3a_x", cx1, 32'h14A); chk("s3a_xv", cv1, 32'h1FE); chk("s3a_done", cd1, 32'h200);
      wait_idle();
      issue(8'hA5, 4'd11, 4'd0);
      capture(10, 0, 0, -1, 8'h0, 4'd0, 4'd0);
      chk("s3b_x", cx0, 32'h14A); chk("s3b_xv", cv0, 32'h1FE); chk("s3b_done", cd0, 32'h200);
      chk("s3b_done_g1", cd1, 32'h200);
      wait_idle();

      // Abort in cycle 3
      issue(8'hA5, 4'd8, 4'd1);
      capture(12, 3, 0, -1, 8'h0, 4'd0, 4'd0);
      chk("s4_x", cx1, 32'hA); chk("s4_xv", cv1, 32'hE);
      chk("s4_busy", cb1, 32'hE); chk("s4_done", cd1 | cd0, 32'h0);
      wait_idle();

      // start_valid held into the done cycle, with abort there ignored
      issue(8'h0D, 4'd4, 4'd1);
      capture(12, 5, 3, 5, 8'h0D, 4'd4, 4'd1);
      chk("s4b_x", cx1, 32'h2D6); chk("s4b_xv", cv1, 32'h3DE); chk("s4b_done", cd1, 32'h420);
      chk("s4b_done_g0", cd0, 32'h420);
      wait_idle();

      // Asynchronous reset during bit 2
      issue(8'h0D, 4'd4, 4'd1);
      @(posedge clk); #3;
      reset_n = 1'b0;
      #1;
      chk("s5_async_g1", {28'b0, x_g1, xv_g1, busy_g1, done_g1}, 32'h0);
      chk("s5_async_g0", {28'b0, x_g0, xv_g0, busy_g0, done_g0}, 32'h0);
      @(negedge clk); #2;
      reset_n = 1'b1;
      issue(8'h0D, 4'd4, 4'd1);
      capture(6, 0, 0, -1, 8'h0, 4'd0, 4'd0);
      chk("s5_x", cx1, 32'h16); chk("s5_xv", cv1, 32'h1E); chk("s5_done", cd1, 32'h20);
      wait_idle();

      // Loopback into a 1101 detector
      issue(8'h0D, 4'd4, 4'd2);
      capture(12, 0, 0, -1, 8'h0, 4'd0, 4'd0);
      chk("s6_det_g0", detect(cx0, cv0, 12), 32'h110);
      chk("s6_det_g1", detect(cx1, cv1, 12), 32'h210);
      wait_idle();

      // Maximum repeat count
      issue(8'h01, 4'd1, 4'd15);
      capture(31, 0, 0, -1, 8'h0, 4'd0, 4'd0);
      chk("s7_xv_g0", cv0, 32'hFFFE); chk("s7_done_g0", cd0, 32'h10000);
      chk("s7_xv_g1", cv1, 32'h2AAAAAAA); chk("s7_done_g1", cd1, 32'h40000000);
      wait_idle();

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sequence_generator.md
Name: sequence_generator

Overview:
- Serial pattern transmitter: accepts a parallel pattern through a valid/ready command handshake and drives it MSB-first onto a 1-bit stream `x`, one bit per clock.
- Optionally repeats the pattern a programmable number of times, with a fixed idle gap between repetitions.
- Sits upstream of the serial sequence detectors; it is the stimulus and transmit end of the same single-bit stream interface.

Parameters:
- WIDTH, 8: maximum pattern length in bits.
- CNT_W, 4: width of the repeat-count field.
- GAP, 1: idle cycles inserted between repetitions (0 = back-to-back).
- LW, $clog2(WIDTH)+1: width of the length field (derived, not overridden).

Ports:
- clk, input, 1: clock, rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- start_valid, input, 1: command valid.
- start_ready, output, 1: command ready; high iff state is IDLE.
- pattern, input, WIDTH: bits to send; `pattern[len-1]` is sent first, `pattern[0]` last.
- len, input, LW: number of bits per repetition.
- reps, input, CNT_W: number of repetitions.
- abort, input, 1: synchronous cancel of an active transmission.
- x, output, 1: serial data, registered.
- x_valid, output, 1: `x` carries a pattern bit this cycle, registered.
- busy, output, 1: transmission in progress, registered.
- done, output, 1: one-cycle completion pulse, registered.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset (`reset_n` low): immediately forces state IDLE and x=0, x_valid=0, busy=0, done=0, with all internal counters and shift register cleared. `start_ready`=1 once `reset_n` is high.
- Accept: on a rising edge with `start_valid` && `start_ready`, latch `pattern`, `len` and `reps`.
  - `len`=0 or `len`>WIDTH is treated as WIDTH.
  - `reps`=0 is treated as 1.
  - Inputs are sampled only on the accept edge; later changes are ignored.
- States:
  - IDLE → SHIFT on accept.
  - SHIFT → GAP after the last bit of a non-final repetition when GAP>0.
  - SHIFT → SHIFT when GAP=0 and repetitions remain.
  - GAP → SHIFT after exactly GAP cycles.
  - SHIFT → IDLE after the last bit of the final repetition.
  - Any state except IDLE → IDLE on `abort`.
- Latency: the first bit, `pattern[len-1]`, appears on `x` with x_valid=1 in the cycle immediately after the accept edge. Each following cycle presents the next lower bit.
- GAP cycles: x=0, x_valid=0, busy=1. Each repetition restarts from `pattern[len-1]`.
- Busy: `busy`=1 from the first-bit cycle through the last-bit cycle, including gaps.
- Total pattern bits = len×reps. Cycles from accept edge to `done` = len×reps + GAP×(reps−1) + 1.
- Completion: in the cycle after the final bit, x=0, x_valid=0, busy=0, done=1 for exactly one cycle, and the state is IDLE with `start_ready`=1.
  - A command accepted at the end of that cycle starts its first bit in the next cycle, so the minimum dead time between commands is 1 cycle.
- Abort: sampled only while `busy`=1.
  - Next cycle: x=0, x_valid=0, busy=0, state IDLE; `done` is NOT asserted.
  - `abort` is ignored in IDLE, including the `done` cycle.
  - `abort` together with an accept in IDLE: the accept wins.
- Outside x_valid: `x` is always 0, never the stale last bit.
- Counters:
  - Bit index counts len−1 down to 0.
  - Repetition counter counts 1..reps in CNT_W+1 bits, so `reps` = 2^CNT_W−1 completes without wrap.
  - Gap counter is sized for GAP, with a minimum width of 1.
- Reset asserted mid-transmission: outputs clear asynchronously with no `done` pulse. The first command after release behaves exactly as after power-on.

Test Plan:
- Single pattern: pattern=8'b0000_1101, len=4, reps=1, accept at cycle 0 → x=1,1,0,1 with x_valid=1 in cycles 1–4; done=1 in cycle 5 only; busy=1 in cycles 1–4.
- Repeats with gap: same pattern, reps=3, GAP=1 → bits in cycles 1–4, 6–9, 11–14; x_valid=0 in cycles 5 and 10; done in cycle 15. Repeat with GAP=0 → 12 contiguous bits, done in cycle 13.
- Length clamp: len=0, then len=WIDTH+3, with pattern=8'hA5 → 8 bits sent, 1,0,1,0,0,1,0,1; done in cycle 9. Also reps=0 → exactly one repetition.
- Abort: len=8, abort asserted in cycle 3 → x_valid=0 and busy=0 from cycle 4 and done never pulses. A start_valid held during the done cycle of a normal run is accepted, and its first bit appears the next cycle.
- Reset mid-operation: drop reset_n asynchronously mid-cycle during bit 2 → x, x_valid, busy and done go to 0 immediately, without waiting for a clock edge. After release, a fresh 4-bit command reproduces scenario 1 timing exactly.
- Loopback: x_valid-gated `x` drives the serial detector's input, with pattern 1101 and reps=2, GAP=0 → the detector output flags exactly at the intended positions, and no false detections occur during IDLE (x held at 0).
